// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared widths, bit-position tables, FSM states and parity helper for the (12,4) LDPC codec
package ldpc_pkg;

    localparam int MSG_W   = 4;
    localparam int CODE_W  = 12;
    localparam int NUM_PAR = 8;
    localparam int IDX_W   = 3;
    localparam int POS_W   = 4;

    // Code index of the parity bit produced at calc step idx; idx 0 sits in the low nibble.
    // Order of production: c11, c10, c9, c8, c7, c6, c5, c3.
    localparam logic [NUM_PAR*POS_W-1:0] PAR_POS_TBL =
        {4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

    // Code index of message bit m[i]; m0 sits in the low nibble (m3->4, m2->2, m1->1, m0->0).
    // The decoder reads its column-swap positions from this same table.
    localparam logic [MSG_W*POS_W-1:0] INFO_POS_TBL = {4'd4, 4'd2, 4'd1, 4'd0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2,
        S_WAIT = 2'd3
    } enc_state_t;

    function automatic logic [POS_W-1:0] par_pos(input logic [IDX_W-1:0] idx);
        return PAR_POS_TBL[{idx, 2'b00} +: POS_W];
    endfunction

    function automatic logic [POS_W-1:0] info_pos(input logic [1:0] bit_i);
        return INFO_POS_TBL[{bit_i, 2'b00} +: POS_W];
    endfunction

    // One parity term per calc step; the case order follows PAR_POS_TBL.
    function automatic logic parity_bit(input logic [IDX_W-1:0] idx,
                                        input logic [MSG_W-1:0] m);
        logic p;
        case (idx)
            3'd0:    p = m[1] ^ m[2] ^ m[3];   // c11
            3'd1:    p = m[0] ^ m[2];          // c10
            3'd2:    p = m[0];                 // c9
            3'd3:    p = m[1] ^ m[2] ^ m[3];   // c8
            3'd4:    p = m[1] ^ m[2] ^ m[3];   // c7
            3'd5:    p = m[2];                 // c6
            3'd6:    p = m[0] ^ m[1] ^ m[2];   // c5
            default: p = m[0] ^ m[1] ^ m[2];   // c3
        endcase
        return p;
    endfunction

endpackage

// File: rtl/ldpc_encoder_if.sv
// rtl/ldpc_encoder_if.sv - message-in / codeword-out handshake bundle of the LDPC encoder
interface ldpc_encoder_if;
    import ldpc_pkg::*;

    logic [MSG_W-1:0]  msg;
    logic              msg_valid;
    logic              msg_ready;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
    logic              busy;

    modport master (
        output msg, msg_valid, code_ready,
        input  msg_ready, code, code_valid, busy
    );

    modport slave (
        input  msg, msg_valid, code_ready,
        output msg_ready, code, code_valid, busy
    );

endinterface

// File: rtl/ldpc_encoder.sv
// rtl/ldpc_encoder.sv - serial (12,4) LDPC encoder with paced, registered codeword output
module ldpc_encoder
    import ldpc_pkg::*;
#(
    parameter int PACE_CYCLES = 26
) (
    input  logic           clk,
    input  logic           rst_n,
    ldpc_encoder_if.slave  io_bus
);

    localparam logic [7:0]       PACE_LAST = 8'(PACE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PAR - 1);

    enc_state_t          r_state;
    enc_state_t          w_state_next;
    logic [MSG_W-1:0]    r_msg_q;
    logic [IDX_W-1:0]    r_idx;
    logic [NUM_PAR-2:0]  r_shadow;
    logic [CODE_W-1:0]   r_code;
    logic                r_code_valid;
    logic [7:0]          r_pace_cnt;

    logic                w_par;
    logic [NUM_PAR-1:0]  w_par_all;
    logic [CODE_W-1:0]   w_code_next;
    logic                w_msg_ready;
    logic                w_busy;

    // The last parity term is used straight from the function on the idx=7 edge,
    // so the shadow only has to hold the first seven (shifted in from the top).
    assign w_par     = parity_bit(r_idx, r_msg_q);
    assign w_par_all = {w_par, r_shadow};

    // Scatter parity terms and message bits into codeword positions via the package tables.
    always_comb begin
        w_code_next = '0;
        for (int i = 0; i < NUM_PAR; i++) begin
            w_code_next[par_pos(IDX_W'(i))] = w_par_all[i];
        end
        for (int i = 0; i < MSG_W; i++) begin
            w_code_next[info_pos(2'(i))] = r_msg_q[i];
        end
    end

    // State register; reset may land at any point, including mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_msg_ready  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_msg_ready = 1'b1;
                w_busy      = 1'b0;
                if (io_bus.msg_valid) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_idx == IDX_LAST) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (io_bus.code_ready) begin
                    w_state_next = (r_pace_cnt >= PACE_LAST) ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_pace_cnt == PACE_LAST) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: message latch, serial parity shadow, codeword register and pace counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msg_q      <= '0;
            r_idx        <= '0;
            r_shadow     <= '0;
            r_code       <= '0;
            r_code_valid <= 1'b0;
            r_pace_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.msg_valid) begin
                        r_msg_q <= io_bus.msg;
                        r_idx   <= '0;
                    end
                end
                S_CALC: begin
                    r_shadow <= {w_par, r_shadow[NUM_PAR-2:1]};
                    r_idx    <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_code       <= w_code_next;
                        r_code_valid <= 1'b1;
                        r_pace_cnt   <= '0;
                    end
                end
                S_OUT: begin
                    if (r_pace_cnt != PACE_LAST) begin
                        r_pace_cnt <= r_pace_cnt + 8'd1;
                    end
                    if (io_bus.code_ready) begin
                        r_code_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_pace_cnt != PACE_LAST) begin
                        r_pace_cnt <= r_pace_cnt + 8'd1;
                    end
                end
                default: begin
                    r_code_valid <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.msg_ready  = w_msg_ready;
    assign io_bus.busy       = w_busy;
    assign io_bus.code       = r_code;
    assign io_bus.code_valid = r_code_valid;

endmodule
